// File: rtl/operand_load_register_pkg.sv
// -----------------------------------------------------------------------------
// operand_pkg
// Shared definitions for the bus-loaded operand registers of the 8-bit
// datapath (accumulator A and operand B).
//   DATA_WIDTH : default datapath width
//   data_t     : one datapath word
//   ZERO_DATA  : all-zero word, the cleared register value
// -----------------------------------------------------------------------------
package operand_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam data_t ZERO_DATA = '0;

endpackage : operand_pkg

// File: rtl/operand_load_register_if.sv
// -----------------------------------------------------------------------------
// operand_load_register_if
// Bus-side signal bundle of one operand register.
//   d      : word from the shared W bus
//   load   : level-sampled load enable
//   n      : negate select for the conditioned output
//   q      : raw stored value (comparator / bus driver)
//   q_out  : conditioned value (adder operand)
//   zero   : q_out == 0, gated low during reset   (only with OPERAND_FLAGS_EN)
//   sign   : q_out MSB, gated low during reset    (only with OPERAND_FLAGS_EN)
// Modports: master drives d/load/n, slave (the register) drives the outputs.
// Optional macro: OPERAND_FLAGS_EN adds the zero/sign flags.
// -----------------------------------------------------------------------------
interface operand_load_register_if
    import operand_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    logic [WIDTH-1:0] d;
    logic             load;
    logic             n;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_out;
`ifdef OPERAND_FLAGS_EN
    logic             zero;
    logic             sign;
`endif

`ifdef OPERAND_FLAGS_EN
    modport master (
        output d, load, n,
        input  q, q_out, zero, sign
    );

    modport slave (
        input  d, load, n,
        output q, q_out, zero, sign
    );
`else
    modport master (
        output d, load, n,
        input  q, q_out
    );

    modport slave (
        input  d, load, n,
        output q, q_out
    );
`endif

endinterface : operand_load_register_if

// File: rtl/operand_load_register_twos_negate.sv
// -----------------------------------------------------------------------------
// twos_negate
// Combinational conditional two's complement.
//   in  : operand
//   en  : 1 = negate, 0 = pass through
//   out : en ? (~in + 1) mod 2^WIDTH : in
// The most negative value maps to itself; no overflow indication is produced.
// -----------------------------------------------------------------------------
module twos_negate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] neg;

    assign neg = WIDTH'(~in + {{(WIDTH-1){1'b0}}, 1'b1});
    assign out = en ? neg : in;

endmodule : twos_negate

// File: rtl/operand_load_register.sv
// -----------------------------------------------------------------------------
// operand_load_register
// Operand register for the 8-bit datapath. Captures the shared W bus on a
// rising clk when load is high and holds otherwise. q_out presents either the
// stored value or its two's complement (n=1), so the adder can form A-B.
//   clk : system clock, rising edge active
//   clr : asynchronous active-low clear of the stored value
//   bus : operand_load_register_if.slave (d, load, n in; q, q_out out,
//         plus zero/sign when OPERAND_FLAGS_EN is defined)
// Optional macro: OPERAND_FLAGS_EN adds zero/sign flags derived from q_out.
// -----------------------------------------------------------------------------
module operand_load_register
    import operand_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            clr,
    operand_load_register_if.slave          bus
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_out_c;

    // Storage: enable-gated flop, so d (even X/Z) is ignored unless load=1.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_r <= '0;
        end else if (bus.load) begin
            q_r <= bus.d;
        end
    end

    assign bus.q = q_r;

    twos_negate #(
        .WIDTH (WIDTH)
    ) u_negate (
        .in  (q_r),
        .en  (bus.n),
        .out (q_out_c)
    );

    assign bus.q_out = q_out_c;

`ifdef OPERAND_FLAGS_EN
    // Flags are forced low while clr is asserted, even though q_out is 0 then.
    assign bus.zero = clr & (q_out_c == '0);
    assign bus.sign = clr & q_out_c[WIDTH-1];
`endif

endmodule : operand_load_register

// File: tb/tb_operand_load_register.sv
// -----------------------------------------------------------------------------
// tb_operand_load_register
// Directed-vector bench for operand_load_register with hand-computed values.
// Flag checks are compiled in when OPERAND_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_operand_load_register;

    localparam int WIDTH = 8;

    logic clk;
    logic clr;
    int   vec_cnt;
    int   err_cnt;
    logic [WIDTH-1:0] sum;

    operand_load_register_if #(.WIDTH(WIDTH)) bus ();

    operand_load_register #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
        end
    endtask

    // Load a value through one rising edge, leave load low afterwards.
    task automatic load_word(input logic [WIDTH-1:0] v);
        @(negedge clk);
        bus.d    = v;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        clr      = 1'b0;
        bus.d    = '0;
        bus.load = 1'b0;
        bus.n    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", bus.q, 8'h00);
        chk("rst_qout", bus.q_out, 8'h00);
        @(negedge clk);
        clr = 1'b1;

        // Reset mid-cycle after a load
        load_word(8'h5A);
        chk("pre_clr_q", bus.q, 8'h5A);
        #2;
        clr = 1'b0;
        #1;
        chk("async_clr_q", bus.q, 8'h00);
        bus.n = 1'b1;
        #0.1;
        chk("clr_qout_n1", bus.q_out, 8'h00);
`ifdef OPERAND_FLAGS_EN
        chk("clr_zero", {7'b0, bus.zero}, 8'h00);
        chk("clr_sign", {7'b0, bus.sign}, 8'h00);
`endif
        @(negedge clk);
        bus.d    = 8'h77;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_blocks_load", bus.q, 8'h00);
        @(negedge clk);
        bus.load = 1'b0;
        bus.n    = 1'b0;
        clr      = 1'b1;

        // Load / hold, with X on d while load is low
        load_word(8'h3C);
        chk("load_3c", bus.q, 8'h3C);
        bus.d = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_3c", bus.q, 8'h3C);
        bus.d = 'x;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_x", bus.q, 8'h3C);

        // Negate
        load_word(8'h05);
        bus.n = 1'b0;
        #1;
        chk("pass_05", bus.q_out, 8'h05);
        bus.n = 1'b1;
        #1;
        chk("neg_05", bus.q_out, 8'hFB);
        chk("neg_q_kept", bus.q, 8'h05);
        sum = 8'h09 + bus.q_out;
        chk("sub_9_5", sum, 8'h04);

        // Boundaries, n=1
        load_word(8'h00);
        chk("neg_00", bus.q_out, 8'h00);
        load_word(8'h80);
        chk("neg_80", bus.q_out, 8'h80);
        load_word(8'hFF);
        chk("neg_ff", bus.q_out, 8'h01);
        load_word(8'h01);
        chk("neg_01", bus.q_out, 8'hFF);

        // Simultaneous load and n change
        @(negedge clk);
        bus.n    = 1'b0;
        bus.d    = 8'h10;
        bus.load = 1'b1;
        #1;
        chk("pre_sim_qout", bus.q_out, 8'h01);
        @(posedge clk);
        bus.n = 1'b1;
        #1;
        bus.load = 1'b0;
        chk("sim_q", bus.q, 8'h10);
        chk("sim_qout", bus.q_out, 8'hF0);

`ifdef OPERAND_FLAGS_EN
        // Flags
        bus.n = 1'b0;
        load_word(8'h00);
        chk("flag_zero_00", {7'b0, bus.zero}, 8'h01);
        chk("flag_sign_00", {7'b0, bus.sign}, 8'h00);
        bus.n = 1'b1;
        load_word(8'h03);
        chk("flag_qout_03", bus.q_out, 8'hFD);
        chk("flag_zero_03", {7'b0, bus.zero}, 8'h00);
        chk("flag_sign_03", {7'b0, bus.sign}, 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_operand_load_register
